// File: rtl/bus_arbiter_if.sv
// Bundles the ibus, dbus and shared memory-bus signals of bus_arbiter.
// slave = arbiter view; master = CPU/memory environment view.
interface bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  ireq_valid;
  logic [ADDR_W-1:0]     ireq_addr;
  logic                  iresp_addr_ok;
  logic                  iresp_data_ok;
  logic [31:0]           iresp_data;

  logic                  dreq_valid;
  logic [ADDR_W-1:0]     dreq_addr;
  logic [2:0]            dreq_size;
  logic [DATA_W/8-1:0]   dreq_strobe;
  logic [DATA_W-1:0]     dreq_data;
  logic                  dresp_addr_ok;
  logic                  dresp_data_ok;
  logic [DATA_W-1:0]     dresp_data;

  logic                  mreq_valid;
  logic [ADDR_W-1:0]     mreq_addr;
  logic [2:0]            mreq_size;
  logic [DATA_W/8-1:0]   mreq_strobe;
  logic [DATA_W-1:0]     mreq_data;
  logic                  mresp_addr_ok;
  logic                  mresp_data_ok;
  logic [DATA_W-1:0]     mresp_data;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
    input  mresp_addr_ok, mresp_data_ok, mresp_data
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
    output mresp_addr_ok, mresp_data_ok, mresp_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Arbitrates ibus/dbus onto one memory bus, one transaction in flight, 2-cycle min latency; mreq held until mresp_addr_ok.
// Define BUS_ARB_RR_EN for alternating (round-robin) priority; default is fixed dbus priority.
module bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_mreq_valid;
  logic [ADDR_W-1:0]   r_mreq_addr;
  logic [2:0]          r_mreq_size;
  logic [STRB_W-1:0]   r_mreq_strobe;
  logic [DATA_W-1:0]   r_mreq_data;

  logic                w_any_req;
  logic                w_grant_d;
  logic                w_addr_fire;
  logic                w_data_fire;
  logic [31:0]         w_iword;

  assign w_any_req = bus.ireq_valid | bus.dreq_valid;

`ifdef BUS_ARB_RR_EN
  logic r_prio_d;

  assign w_grant_d = bus.dreq_valid & (~bus.ireq_valid | r_prio_d);

  // The port that just finished yields priority on the next conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio_d <= 1'b1;
    end else if (w_data_fire) begin
      r_prio_d <= (r_owner == OWN_I);
    end
  end
`else
  assign w_grant_d = bus.dreq_valid;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_I;
      r_mreq_valid  <= 1'b0;
      r_mreq_addr   <= '0;
      r_mreq_size   <= '0;
      r_mreq_strobe <= '0;
      r_mreq_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_REQ;
            r_mreq_valid <= 1'b1;
            if (w_grant_d) begin
              r_owner       <= OWN_D;
              r_mreq_addr   <= bus.dreq_addr;
              r_mreq_size   <= bus.dreq_size;
              r_mreq_strobe <= bus.dreq_strobe;
              r_mreq_data   <= bus.dreq_data;
            end else begin
              r_owner       <= OWN_I;
              r_mreq_addr   <= bus.ireq_addr;
              r_mreq_size   <= 3'b010;
              r_mreq_strobe <= '0;
              r_mreq_data   <= '0;
            end
          end
        end
        S_REQ: begin
          // data_ok without addr_ok is stray and ignored here.
          if (bus.mresp_addr_ok) begin
            r_mreq_valid <= 1'b0;
            r_state      <= bus.mresp_data_ok ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mresp_data_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_mreq_valid <= 1'b0;
        end
      endcase
    end
  end

  assign w_addr_fire = rst & (r_state == S_REQ) & bus.mresp_addr_ok;
  assign w_data_fire = rst & bus.mresp_data_ok &
                       ((r_state == S_WAIT) | ((r_state == S_REQ) & bus.mresp_addr_ok));

  assign w_iword = r_mreq_addr[2] ? bus.mresp_data[63:32] : bus.mresp_data[31:0];

  assign bus.iresp_addr_ok = w_addr_fire & (r_owner == OWN_I);
  assign bus.iresp_data_ok = w_data_fire & (r_owner == OWN_I);
  assign bus.iresp_data    = w_iword;
  assign bus.dresp_addr_ok = w_addr_fire & (r_owner == OWN_D);
  assign bus.dresp_data_ok = w_data_fire & (r_owner == OWN_D);
  assign bus.dresp_data    = bus.mresp_data;

  assign bus.mreq_valid    = r_mreq_valid;
  assign bus.mreq_addr     = r_mreq_addr;
  assign bus.mreq_size     = r_mreq_size;
  assign bus.mreq_strobe   = r_mreq_strobe;
  assign bus.mreq_data     = r_mreq_data;

`ifndef SYNTHESIS
  a_single_data_ok: assert property (@(posedge clk) disable iff (!rst)
    !(bus.iresp_data_ok && bus.dresp_data_ok));
  a_req_hold: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_REQ && !bus.mresp_addr_ok) |=> (r_mreq_valid && $stable(r_mreq_addr)));
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; round-robin ordering checked when BUS_ARB_RR_EN is defined.
module tb_bus_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.ireq_valid    = 1'b0;
    bus.ireq_addr     = '0;
    bus.dreq_valid    = 1'b0;
    bus.dreq_addr     = '0;
    bus.dreq_size     = '0;
    bus.dreq_strobe   = '0;
    bus.dreq_data     = '0;
    bus.mresp_addr_ok = 1'b0;
    bus.mresp_data_ok = 1'b0;
    bus.mresp_data    = '0;
  endtask

  task automatic test_reset();
    logic [139:0] got;
    logic [3:0]   oks;
    idle_inputs();
    rst = 1'b0;
    bus.ireq_valid = 1'b1;
    bus.dreq_valid = 1'b1;
    bus.mresp_addr_ok = 1'b1;
    bus.mresp_data_ok = 1'b1;
    #3;
    got = {bus.mreq_valid, bus.mreq_addr, bus.mreq_size, bus.mreq_strobe, bus.mreq_data};
    n_checks++; if (got !== 140'h0) begin n_fail++; $display("FAIL reset_mreq got %h exp 0", got); end
    oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
    n_checks++; if (oks !== 4'b0000) begin n_fail++; $display("FAIL reset_oks got %b exp 0000", oks); end
    step(); step();
    n_checks++; if (bus.mreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_mvalid got %b exp 0", bus.mreq_valid); end
    idle_inputs();
    step();
    rst = 1'b1;
    bus.dreq_valid = 1'b1;
    bus.dreq_addr  = 64'h8000_0040;
    bus.dreq_size  = 3'b011;
    settle();
    n_checks++; if (bus.mreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_nogrant got %b exp 0", bus.mreq_valid); end
    step();
    n_checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== 64'h8000_0040) begin
      n_fail++; $display("FAIL reset_first_grant got v=%b a=%h exp v=1 a=8000_0040", bus.mreq_valid, bus.mreq_addr); end
    bus.dreq_valid = 1'b0;
    bus.mresp_addr_ok = 1'b1;
    bus.mresp_data_ok = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_ibus_read();
    logic [63:0]  addrs [2];
    logic [31:0]  words [2];
    logic [139:0] got, exp;
    logic [3:0]   oks;
    addrs[0] = 64'h8000_0004; words[0] = 32'h1111_2222;
    addrs[1] = 64'h8000_0000; words[1] = 32'h3333_4444;
    for (int k = 0; k < 2; k++) begin
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = addrs[k];
      settle();
      n_checks++; if (bus.mreq_valid !== 1'b0) begin n_fail++; $display("FAIL ibus_pre_grant[%0d] got %b exp 0", k, bus.mreq_valid); end
      step();
      got = {bus.mreq_valid, bus.mreq_addr, bus.mreq_size, bus.mreq_strobe, bus.mreq_data};
      exp = {1'b1, addrs[k], 3'b010, 8'h00, 64'h0};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ibus_mreq[%0d] got %h exp %h", k, got, exp); end
      bus.ireq_valid = 1'b0;
      bus.mresp_addr_ok = 1'b1;
      settle();
      oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
      n_checks++; if (oks !== 4'b1000) begin n_fail++; $display("FAIL ibus_addr_ok[%0d] got %b exp 1000", k, oks); end
      step();
      bus.mresp_addr_ok = 1'b0;
      bus.mresp_data_ok = 1'b1;
      bus.mresp_data    = 64'h1111_2222_3333_4444;
      settle();
      oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
      n_checks++; if (oks !== 4'b0100) begin n_fail++; $display("FAIL ibus_data_ok[%0d] got %b exp 0100", k, oks); end
      n_checks++; if (bus.iresp_data !== words[k]) begin n_fail++; $display("FAIL ibus_data[%0d] got %h exp %h", k, bus.iresp_data, words[k]); end
      n_checks++; if (bus.mreq_valid !== 1'b0) begin n_fail++; $display("FAIL ibus_wait_mvalid[%0d] got %b exp 0", k, bus.mreq_valid); end
      step();
      bus.mresp_data_ok = 1'b0;
      settle();
      oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
      n_checks++; if (oks !== 4'b0000) begin n_fail++; $display("FAIL ibus_pulse_end[%0d] got %b exp 0000", k, oks); end
      step();
    end
  endtask

  task automatic test_priority();
    logic own [4];
    logic [63:0] exp_addr;
    logic [3:0]  oks;
    int n;
`ifdef BUS_ARB_RR_EN
    n = 4; own[0] = 1'b1; own[1] = 1'b0; own[2] = 1'b1; own[3] = 1'b0;
`else
    n = 2; own[0] = 1'b1; own[1] = 1'b0; own[2] = 1'b0; own[3] = 1'b0;
`endif
    bus.ireq_valid  = 1'b1;
    bus.ireq_addr   = 64'h8000_0000;
    bus.dreq_valid  = 1'b1;
    bus.dreq_addr   = 64'h8000_1000;
    bus.dreq_size   = 3'b011;
    bus.dreq_strobe = 8'hFF;
    bus.dreq_data   = 64'h0000_0000_DEAD_BEEF;
    for (int k = 0; k < n; k++) begin
      step();
      exp_addr = own[k] ? 64'h8000_1000 : 64'h8000_0000;
      n_checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== exp_addr) begin
        n_fail++; $display("FAIL prio_grant[%0d] got v=%b a=%h exp v=1 a=%h", k, bus.mreq_valid, bus.mreq_addr, exp_addr); end
      if (own[k]) begin
        n_checks++; if ({bus.mreq_size, bus.mreq_strobe, bus.mreq_data} !== {3'b011, 8'hFF, 64'h0000_0000_DEAD_BEEF}) begin
          n_fail++; $display("FAIL prio_dfields[%0d] got %h %h %h exp 3 ff deadbeef", k, bus.mreq_size, bus.mreq_strobe, bus.mreq_data); end
      end
`ifndef BUS_ARB_RR_EN
      if (k == 0) bus.dreq_valid = 1'b0;
`endif
      bus.mresp_addr_ok = 1'b1;
      settle();
      oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
      n_checks++; if (oks !== (own[k] ? 4'b0010 : 4'b1000)) begin n_fail++; $display("FAIL prio_addr_ok[%0d] got %b owner %b", k, oks, own[k]); end
      step();
      bus.mresp_addr_ok = 1'b0;
      bus.mresp_data_ok = 1'b1;
      bus.mresp_data    = 64'h0123_4567_89AB_CDEF + 64'(k);
      if (k == n - 1) begin
        bus.ireq_valid = 1'b0;
        bus.dreq_valid = 1'b0;
      end
      settle();
      oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
      n_checks++; if (oks !== (own[k] ? 4'b0001 : 4'b0100)) begin n_fail++; $display("FAIL prio_data_ok[%0d] got %b owner %b", k, oks, own[k]); end
      if (own[k]) begin
        n_checks++; if (bus.dresp_data !== 64'h0123_4567_89AB_CDEF + 64'(k)) begin n_fail++; $display("FAIL prio_ddata[%0d] got %h", k, bus.dresp_data); end
      end else begin
        n_checks++; if (bus.iresp_data !== 32'h89AB_CDEF + 32'(k)) begin n_fail++; $display("FAIL prio_idata[%0d] got %h exp %h", k, bus.iresp_data, 32'h89AB_CDEF + 32'(k)); end
      end
      step();
      bus.mresp_data_ok = 1'b0;
      settle();
      n_checks++; if (bus.mreq_valid !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap[%0d] got %b exp 0", k, bus.mreq_valid); end
    end
    step();
    idle_inputs();
  endtask

  task automatic test_addr_stall();
    logic [139:0] got, exp;
    logic [3:0]   oks;
    bus.dreq_valid  = 1'b1;
    bus.dreq_addr   = 64'h8000_3008;
    bus.dreq_size   = 3'b011;
    bus.dreq_strobe = 8'hF0;
    bus.dreq_data   = 64'h0123_4567_89AB_CDEF;
    step();
    bus.dreq_valid  = 1'b0;
    bus.dreq_addr   = 64'h0;
    bus.dreq_strobe = 8'h0F;
    bus.dreq_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    exp = {1'b1, 64'h8000_3008, 3'b011, 8'hF0, 64'h0123_4567_89AB_CDEF};
    for (int c = 0; c < 5; c++) begin
      settle();
      got = {bus.mreq_valid, bus.mreq_addr, bus.mreq_size, bus.mreq_strobe, bus.mreq_data};
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL stall_mreq[%0d] got %h exp %h", c, got, exp); end
      oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
      n_checks++; if (oks !== 4'b0000) begin n_fail++; $display("FAIL stall_oks[%0d] got %b exp 0000", c, oks); end
      step();
    end
    bus.mresp_addr_ok = 1'b1;
    settle();
    n_checks++; if (bus.dresp_addr_ok !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b exp 1", bus.dresp_addr_ok); end
    step();
    bus.mresp_addr_ok = 1'b0;
    bus.mresp_data_ok = 1'b1;
    settle();
    n_checks++; if (bus.dresp_data_ok !== 1'b1) begin n_fail++; $display("FAIL stall_data_ok got %b exp 1", bus.dresp_data_ok); end
    step();
    idle_inputs();
  endtask

  task automatic test_spurious();
    logic [3:0] oks;
    bus.mresp_addr_ok = 1'b1;
    bus.mresp_data_ok = 1'b1;
    settle();
    oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
    n_checks++; if (oks !== 4'b0000) begin n_fail++; $display("FAIL spur_idle_oks got %b exp 0000", oks); end
    step();
    n_checks++; if (bus.mreq_valid !== 1'b0) begin n_fail++; $display("FAIL spur_idle_state got %b exp 0", bus.mreq_valid); end
    idle_inputs();
    bus.dreq_valid = 1'b1;
    bus.dreq_addr  = 64'h8000_0010;
    bus.dreq_size  = 3'b011;
    step();
    bus.dreq_valid = 1'b0;
    bus.mresp_data_ok = 1'b1;
    settle();
    oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
    n_checks++; if (oks !== 4'b0000) begin n_fail++; $display("FAIL spur_req_oks got %b exp 0000", oks); end
    step();
    bus.mresp_data_ok = 1'b0;
    settle();
    n_checks++; if (bus.mreq_valid !== 1'b1) begin n_fail++; $display("FAIL spur_req_state got %b exp 1", bus.mreq_valid); end
    bus.mresp_addr_ok = 1'b1;
    step();
    bus.mresp_addr_ok = 1'b0;
    bus.mresp_data_ok = 1'b1;
    settle();
    n_checks++; if (bus.dresp_data_ok !== 1'b1) begin n_fail++; $display("FAIL spur_complete got %b exp 1", bus.dresp_data_ok); end
    step();
    idle_inputs();
  endtask

  task automatic test_combined();
    logic [3:0] oks;
    bus.dreq_valid = 1'b1;
    bus.dreq_addr  = 64'h8000_2000;
    bus.dreq_size  = 3'b011;
    step();
    bus.dreq_valid    = 1'b0;
    bus.mresp_addr_ok = 1'b1;
    bus.mresp_data_ok = 1'b1;
    bus.mresp_data    = 64'hCAFE_F00D_1234_5678;
    settle();
    oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
    n_checks++; if (oks !== 4'b0011) begin n_fail++; $display("FAIL comb_oks got %b exp 0011", oks); end
    n_checks++; if (bus.dresp_data !== 64'hCAFE_F00D_1234_5678) begin n_fail++; $display("FAIL comb_data got %h exp cafef00d12345678", bus.dresp_data); end
    step();
    idle_inputs();
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h8000_0004;
    settle();
    oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
    n_checks++; if (oks !== 4'b0000 || bus.mreq_valid !== 1'b0) begin n_fail++; $display("FAIL comb_idle got oks=%b v=%b exp 0000 0", oks, bus.mreq_valid); end
    step();
    n_checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== 64'h8000_0004) begin
      n_fail++; $display("FAIL comb_regrant got v=%b a=%h exp v=1 a=8000_0004", bus.mreq_valid, bus.mreq_addr); end
    bus.ireq_valid    = 1'b0;
    bus.mresp_addr_ok = 1'b1;
    bus.mresp_data_ok = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [139:0] got;
    logic [3:0]   oks;
    bus.dreq_valid = 1'b1;
    bus.dreq_addr  = 64'h8000_4000;
    bus.dreq_size  = 3'b011;
    step();
    bus.dreq_valid    = 1'b0;
    bus.mresp_addr_ok = 1'b1;
    step();
    bus.mresp_addr_ok = 1'b0;
    rst = 1'b0;
    #1;
    got = {bus.mreq_valid, bus.mreq_addr, bus.mreq_size, bus.mreq_strobe, bus.mreq_data};
    n_checks++; if (got !== 140'h0) begin n_fail++; $display("FAIL midrst_mreq got %h exp 0", got); end
    step(); step();
    rst = 1'b1;
    bus.mresp_data_ok = 1'b1;
    bus.mresp_data    = 64'h5555_6666_7777_8888;
    settle();
    oks = {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok, bus.dresp_data_ok};
    n_checks++; if (oks !== 4'b0000) begin n_fail++; $display("FAIL midrst_late_data got %b exp 0000", oks); end
    step();
    bus.mresp_data_ok = 1'b0;
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h8000_0008;
    settle();
    n_checks++; if (bus.mreq_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b exp 0", bus.mreq_valid); end
    step();
    n_checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== 64'h8000_0008 || bus.mreq_size !== 3'b010) begin
      n_fail++; $display("FAIL midrst_regrant got v=%b a=%h s=%b exp v=1 a=8000_0008 s=010", bus.mreq_valid, bus.mreq_addr, bus.mreq_size); end
    bus.ireq_valid    = 1'b0;
    bus.mresp_addr_ok = 1'b1;
    bus.mresp_data_ok = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ibus_read();
    test_priority();
    test_addr_stall();
    test_spurious();
    test_combined();
    test_reset_mid();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
